// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, up to two
// results broadcast per cycle on CDB/CDB2 in round-robin order.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ROB_W = 6,
  parameter int DATA_W = 32,
  parameter logic [ROB_W-1:0] INVALID_ROB = 6'b010000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      CDBiscast,
  output logic [ROB_W-1:0]          CDBrobNum,
  output logic [DATA_W-1:0]         CDBdata,
  output logic                      CDBiscast2,
  output logic [ROB_W-1:0]          CDBrobNum2,
  output logic [DATA_W-1:0]         CDBdata2
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] slot_v;
  logic [ROB_W-1:0]   slot_rob [NUM_REQ];
  logic [DATA_W-1:0]  slot_data [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;

  logic               g0_v, g1_v;
  logic [PTR_W-1:0]   g0, g1;
  logic [PTR_W-1:0]   scan_idx;
  logic [NUM_REQ-1:0] grant_mask;
  logic [NUM_REQ-1:0] accept;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  // Walk the slots starting at rr_ptr; the first two valid ones win the buses.
  always_comb begin
    g0_v = 1'b0;
    g1_v = 1'b0;
    g0 = '0;
    g1 = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (slot_v[scan_idx]) begin
        if (!g0_v) begin
          g0_v = 1'b1;
          g0 = scan_idx;
        end else if (!g1_v) begin
          g1_v = 1'b1;
          g1 = scan_idx;
        end
      end
    end
  end

  always_comb begin
    grant_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_mask[i] = (g0_v && g0 == PTR_W'(i)) || (g1_v && g1 == PTR_W'(i));
    end
  end

  // A slot being drained this cycle can be refilled on the same edge.
  assign req_ready = {NUM_REQ{!flush}} & (~slot_v | grant_mask);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        slot_rob[i]  <= req_rob[i*ROB_W +: ROB_W];
        slot_data[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_v     <= '0;
      rr_ptr     <= '0;
      CDBiscast  <= 1'b0;
      CDBrobNum  <= INVALID_ROB;
      CDBdata    <= '0;
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= INVALID_ROB;
      CDBdata2   <= '0;
    end else if (flush) begin
      slot_v     <= '0;
      rr_ptr     <= '0;
      CDBiscast  <= 1'b0;
      CDBrobNum  <= INVALID_ROB;
      CDBdata    <= '0;
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= INVALID_ROB;
      CDBdata2   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) slot_v[i] <= 1'b1;
        else if (grant_mask[i]) slot_v[i] <= 1'b0;
      end
      CDBiscast  <= g0_v;
      CDBrobNum  <= g0_v ? slot_rob[g0] : INVALID_ROB;
      CDBdata    <= g0_v ? slot_data[g0] : '0;
      CDBiscast2 <= g1_v;
      CDBrobNum2 <= g1_v ? slot_rob[g1] : INVALID_ROB;
      CDBdata2   <= g1_v ? slot_data[g1] : '0;
      if (g1_v) rr_ptr <= wrap_inc(g1);
      else if (g0_v) rr_ptr <= wrap_inc(g0);
    end
  end

endmodule
